// File: rtl/vh_parity_decoder.sv
// vh_parity_decoder: two-stage row/column parity decoder for a 24-bit codeword
// (16 data bits laid out as a 4x4 matrix, 4 row parity bits, 4 column parity bits).
// Stage 1 computes the row/column syndromes; stage 2 classifies them and corrects
// a single data bit when exactly one row and one column disagree.
// Optional statistics counters are compiled in when VH_DEC_STATS_EN is defined.
module vh_parity_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [1:0]       out_status,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_DATA   = 2'b01;
    localparam logic [1:0] ST_PARITY = 2'b10;
    localparam logic [1:0] ST_UNCORR = 2'b11;

    // Whole pipeline moves together; a stalled output freezes both stages.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1 syndromes: one XOR tree per row and per column, parity bit folded in.
    logic [3:0] sr_d;
    logic [3:0] sc_d;
    for (genvar gi = 0; gi < 4; gi++) begin : g_syn
        assign sr_d[gi] = (^in_code[4*gi +: 4]) ^ in_code[16+gi];
        assign sc_d[gi] = in_code[gi] ^ in_code[gi+4] ^ in_code[gi+8] ^ in_code[gi+12]
                        ^ in_code[20+gi];
    end

    logic        s1_valid_q;
    logic [3:0]  s1_sr_q;
    logic [3:0]  s1_sc_q;
    logic [15:0] s1_data_q;

    // Stage 1 register: capture syndromes and raw data; a low in_valid becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sr_q    <= '0;
            s1_sc_q    <= '0;
            s1_data_q  <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sr_q   <= sr_d;
                s1_sc_q   <= sc_d;
                s1_data_q <= in_code[15:0];
            end
        end
    end

    // Candidate flip position: the AND of a failing row and failing column. It is
    // only applied when both syndromes are one-hot, so at most one bit is set then.
    logic [15:0] flip_mask;
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            assign flip_mask[4*gi+gj] = s1_sr_q[gi] & s1_sc_q[gj];
        end
    end

    logic sr_zero, sc_zero, sr_one, sc_one;
    assign sr_zero = (s1_sr_q == 4'd0);
    assign sc_zero = (s1_sc_q == 4'd0);
    assign sr_one  = !sr_zero && ((s1_sr_q & (s1_sr_q - 4'd1)) == 4'd0);
    assign sc_one  = !sc_zero && ((s1_sc_q & (s1_sc_q - 4'd1)) == 4'd0);

    logic [15:0] data_d;
    logic [1:0]  status_d;

    // Stage 2 classification; anything other than the three recognised patterns
    // passes the data through untouched so multi-bit errors are never miscorrected.
    always_comb begin
        data_d   = s1_data_q;
        status_d = ST_UNCORR;
        if (sr_zero && sc_zero) begin
            status_d = ST_CLEAN;
        end else if (sr_one && sc_one) begin
            data_d   = s1_data_q ^ flip_mask;
            status_d = ST_DATA;
        end else if ((sr_one && sc_zero) || (sr_zero && sc_one)) begin
            status_d = ST_PARITY;
        end
    end

    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic [1:0]  out_status_q;

    // Stage 2 / output register: holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= ST_CLEAN;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= data_d;
                out_status_q <= status_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;

`ifdef VH_DEC_STATS_EN
    logic             out_hs;
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_q;
    assign out_hs = out_valid_q && out_ready;

    // Saturating event counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (out_hs) begin
            if ((out_status_q == ST_DATA || out_status_q == ST_PARITY) && (corr_cnt_q != '1))
                corr_cnt_q <= corr_cnt_q + 1'b1;
            if ((out_status_q == ST_UNCORR) && (uncorr_cnt_q != '1))
                uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_vh_parity_decoder.sv
// Testbench for vh_parity_decoder: directed vectors plus randomized codewords with
// random output back-pressure. A driver pushes expected results into a queue on
// each accepted input; a monitor pops and compares on each output handshake.
module tb_vh_parity_decoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_code;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [1:0]       out_status;
    logic             stat_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    vh_parity_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status),
        .stat_clr(stat_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: even parity per row/column of the 4x4 matrix, then the decode rules.
    function automatic logic [23:0] encode(input logic [15:0] data);
        logic [23:0] code;
        code = {8'h00, data};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                code[16+r] = code[16+r] ^ data[4*r+c];
                code[20+c] = code[20+c] ^ data[4*r+c];
            end
        return code;
    endfunction

    function automatic exp_t ref_decode(input logic [23:0] code);
        exp_t e;
        int nr = 0, nc = 0, br = 0, bc = 0;
        logic p;
        for (int r = 0; r < 4; r++) begin
            p = code[16+r];
            for (int c = 0; c < 4; c++) p = p ^ code[4*r+c];
            if (p) begin nr++; br = r; end
        end
        for (int c = 0; c < 4; c++) begin
            p = code[20+c];
            for (int r = 0; r < 4; r++) p = p ^ code[4*r+c];
            if (p) begin nc++; bc = c; end
        end
        e.d = code[15:0];
        if (nr == 0 && nc == 0)      e.s = 2'b00;
        else if (nr == 1 && nc == 1) begin e.d[4*br+bc] = ~e.d[4*br+bc]; e.s = 2'b01; end
        else if (nr + nc == 1)       e.s = 2'b10;
        else                         e.s = 2'b11;
        return e;
    endfunction

    // One clock cycle of stimulus; called just after a rising edge, returns likewise.
    task automatic drive_cycle(input bit v, input logic [23:0] code, input exp_t e,
                               input bit rdy, input bit clr, output bit acc, output bit ov);
        exp_t tmp;
        in_valid  = v;
        in_code   = code;
        out_ready = rdy;
        stat_clr  = clr;
        @(negedge clk);
        acc = v && in_ready;
        ov  = out_valid;
        if (acc) begin
            tmp = e;
            exp_q.push_back(tmp);
            $display("IN   code=0x%06h exp data=0x%04h status=%0d", code, e.d, e.s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] code, input exp_t e, input string name);
        bit acc, ov;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            drive_cycle(1'b1, code, e, 1'b1, 1'b0, acc, ov);
            n++;
        end
        check({name, "_accept"}, {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit acc, ov;
        exp_t z;
        z = '0;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 24'h0, z, rdy, 1'b0, acc, ov);
    endtask

    // Monitor: protocol, hold-while-stalled, scoreboard and counter model.
    logic        hold_prev = 0;
    logic [15:0] prev_data;
    logic [1:0]  prev_status;
    int          m_corr = 0, m_uncorr = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   hs_corr, hs_uncorr;
        hs_corr = 0;
        hs_uncorr = 0;
        if (started) begin
`ifdef VH_DEC_STATS_EN
            check("corr_cnt", {16'd0, corr_cnt}, m_corr);
            check("uncorr_cnt", {16'd0, uncorr_cnt}, m_uncorr);
`else
            check("corr_cnt_absent", {16'd0, corr_cnt}, 32'd0);
            check("uncorr_cnt_absent", {16'd0, uncorr_cnt}, 32'd0);
`endif
            if (rst) begin
                hold_prev = 0;
            end else begin
                check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                if (hold_prev) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_data", {16'd0, out_data}, {16'd0, prev_data});
                    check("hold_status", {30'd0, out_status}, {30'd0, prev_status});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data=0x%04h status=%0d, expected none",
                                 out_data, out_status);
                    end else begin
                        e = exp_q.pop_front();
                        $display("OUT  data=0x%04h status=%0d", out_data, out_status);
                        check("out_data", {16'd0, out_data}, {16'd0, e.d});
                        check("out_status", {30'd0, out_status}, {30'd0, e.s});
                        hs_corr   = (e.s == 2'b01 || e.s == 2'b10);
                        hs_uncorr = (e.s == 2'b11);
                    end
                end
                hold_prev   = out_valid && !out_ready;
                prev_data   = out_data;
                prev_status = out_status;
            end
            if (rst || stat_clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end else begin
                if (hs_corr && m_corr < (2**CNT_W - 1)) m_corr++;
                if (hs_uncorr && m_uncorr < (2**CNT_W - 1)) m_uncorr++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc, ov;
        exp_t e;
        logic [23:0] code;
        int nf;

        rst = 1; in_valid = 0; in_code = '0; out_ready = 0; stat_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {16'd0, out_data}, 32'd0);
        check("reset_out_status", {30'd0, out_status}, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        started = 1;
        @(negedge clk);
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Latency: output appears exactly two cycles after the accept cycle.
        e = '{d: 16'h0000, s: 2'b00};
        drive_cycle(1'b1, 24'h000000, e, 1'b1, 1'b0, acc, ov);
        check("lat_accept", {31'd0, acc}, 32'd1);
        drive_cycle(1'b0, 24'h0, e, 1'b1, 1'b0, acc, ov);
        check("lat_cycle1_no_valid", {31'd0, ov}, 32'd0);
        drive_cycle(1'b0, 24'h0, e, 1'b1, 1'b0, acc, ov);
        check("lat_cycle2_valid", {31'd0, ov}, 32'd1);
        idle(2, 1'b1);

        send(24'h000020, '{d: 16'h0000, s: 2'b01}, "data_bit5");
        send(24'h100001, '{d: 16'h0001, s: 2'b10}, "row_parity");
        send(24'h000021, '{d: 16'h0021, s: 2'b11}, "double_err");
        idle(4, 1'b1);

        // Back-to-back stream with a 3-cycle stall on the first output.
        send(24'h00FFFF, '{d: 16'hFFFF, s: 2'b00}, "stream_a");
        send(24'h110001, '{d: 16'h0001, s: 2'b00}, "stream_b");
        e = '{d: 16'hFFFF, s: 2'b01};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 24'h00FFFE, e, 1'b0, 1'b0, acc, ov);
            check("stall_no_accept", {31'd0, acc}, 32'd0);
            check("stall_out_valid", {31'd0, ov}, 32'd1);
        end
        send(24'h00FFFE, e, "stream_c");
        idle(4, 1'b1);

        // Reset with two codewords in flight: both are discarded.
        send(24'h000001, ref_decode(24'h000001), "rst_a");
        send(24'h000002, ref_decode(24'h000002), "rst_b");
        rst = 1; in_valid = 0; out_ready = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle(6, 1'b1);

        // Randomized codewords: 0..3 random bit flips, random back-pressure and clears.
        for (int i = 0; i < 400; i++) begin
            code = encode(16'($urandom));
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) code[$urandom_range(0, 23)] ^= 1'b1;
            drive_cycle(($urandom % 4) != 0, code, ref_decode(code),
                        ($urandom % 4) != 0, ($urandom % 32) == 0, acc, ov);
        end
        idle(10, 1'b1);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
